// File: rtl/cube_frame_rx.sv
// cube_frame_rx: byte-stream frame receiver for the 8x8x8 LED cube.
// Collects a 64-byte frame into a shadow buffer and publishes it to Cells
// in one step, so the display side never sees a half-loaded frame.
// Byte k lands in bits [8k+7:8k]; bit index is z*64 + y*8 + x.
// Optional build macro: CUBE_RX_TIMEOUT_EN adds an inter-byte watchdog that
// drops a stalled partial frame after TIMEOUT_CYCLES idle cycles in LOAD.

`timescale 1ns/1ps

module cube_frame_rx #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [7:0]   DataIn,
    input  logic         DataValid,
    input  logic         Sof,
    output logic         DataReady,
    output logic [511:0] Cells,
    output logic         FrameDone,
    output logic         FrameErr,
    output logic         Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } rxState_t;

    rxState_t     state;
    rxState_t     nextState;
    logic [5:0]   byteCount;
    logic [5:0]   nextCount;
    logic [5:0]   writeIndex;
    logic [503:0] shadow;
    logic         accept;
    logic         writeByte;
    logic         commitFrame;
    logic         errEvent;
    logic         timeoutHit;

    // The source only sees a handshake when our registered ready is high.
    assign accept = DataValid & DataReady;

`ifdef CUBE_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdCount;

    // Watchdog counts idle LOAD cycles; any accept or leaving LOAD restarts it.
    always_ff @(posedge Clk) begin
        if (Reset || (state != LOAD) || accept) begin
            wdCount <= '0;
        end else begin
            wdCount <= wdCount + 1'b1;
        end
    end

    assign timeoutHit = (state == LOAD) && !accept &&
                        (wdCount == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeoutParam;

    assign unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
    assign timeoutHit         = 1'b0;
`endif

    // Next-state and per-byte actions; byte 63 bypasses the shadow and goes
    // straight into Cells together with the already-loaded 63 bytes.
    always_comb begin
        nextState   = state;
        nextCount   = byteCount;
        writeByte   = 1'b0;
        writeIndex  = byteCount;
        commitFrame = 1'b0;
        errEvent    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (Sof) begin
                        writeByte  = 1'b1;
                        writeIndex = 6'd0;
                        nextCount  = 6'd1;
                        nextState  = LOAD;
                    end else begin
                        errEvent = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (Sof) begin
                        errEvent   = 1'b1;
                        writeByte  = 1'b1;
                        writeIndex = 6'd0;
                        nextCount  = 6'd1;
                    end else if (byteCount == 6'd63) begin
                        commitFrame = 1'b1;
                        nextCount   = 6'd0;
                        nextState   = COMMIT;
                    end else begin
                        writeByte = 1'b1;
                        nextCount = byteCount + 6'd1;
                    end
                end else if (timeoutHit) begin
                    errEvent  = 1'b1;
                    nextCount = 6'd0;
                    nextState = IDLE;
                end
            end
            COMMIT: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register, byte counter and registered handshake/status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            byteCount <= 6'd0;
            DataReady <= 1'b0;
            Busy      <= 1'b0;
            FrameDone <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            state     <= nextState;
            byteCount <= nextCount;
            DataReady <= (nextState != COMMIT);
            Busy      <= (nextState == LOAD);
            FrameDone <= commitFrame;
            FrameErr  <= errEvent;
        end
    end

    // Shadow buffer holds bytes 0..62 of the frame being assembled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow <= '0;
        end else begin
            for (int k = 0; k < 63; k++) begin
                if (writeByte && (writeIndex == 6'(k))) begin
                    shadow[k*8 +: 8] <= DataIn;
                end
            end
        end
    end

    // Published cell vector changes only on a commit or on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Cells <= '0;
        end else if (commitFrame) begin
            Cells <= {DataIn, shadow};
        end
    end

endmodule

// File: tb/tb_cube_frame_rx.sv
// tb_cube_frame_rx: self-checking bench for cube_frame_rx.
// A protocol model fed by the driver pushes expected frames, done/err pulse
// times onto queues; a negedge monitor pops and compares as the DUT reports.
// Build with CUBE_RX_TIMEOUT_EN defined to exercise the watchdog variant.

`timescale 1ns/1ps

module tb_cube_frame_rx;

    localparam int TIMEOUT_CYCLES = 16;

    logic         Clk;
    logic         Reset;
    logic [7:0]   DataIn;
    logic         DataValid;
    logic         Sof;
    logic         DataReady;
    logic [511:0] Cells;
    logic         FrameDone;
    logic         FrameErr;
    logic         Busy;

    int checkCount = 0;
    int failCount  = 0;
    int negCount   = 0;
    int lastAcceptNeg = 0;
    int lastWait = 0;

    logic [511:0] modelShadow = '0;
    logic [511:0] modelCells  = '0;
    int           modelCount  = 0;
    bit           modelBusy   = 1'b0;

    logic [511:0] frameQ[$];
    int           doneQ[$];
    int           errQ[$];

    cube_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DataIn    (DataIn),
        .DataValid (DataValid),
        .Sof       (Sof),
        .DataReady (DataReady),
        .Cells     (Cells),
        .FrameDone (FrameDone),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time bound exceeded");
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Protocol model: what the receiver must do with one accepted byte.
    task automatic modelAccept(input logic [7:0] d, input logic s);
        if (s) begin
            if (modelBusy) errQ.push_back(lastAcceptNeg);
            modelShadow[7:0] = d;
            modelCount = 1;
            modelBusy  = 1'b1;
        end else if (!modelBusy) begin
            errQ.push_back(lastAcceptNeg);
        end else begin
            modelShadow[modelCount*8 +: 8] = d;
            if (modelCount == 63) begin
                modelCells = modelShadow;
                frameQ.push_back(modelShadow);
                doneQ.push_back(lastAcceptNeg);
                modelBusy  = 1'b0;
                modelCount = 0;
            end else begin
                modelCount++;
            end
        end
    endtask

    // Offer one byte from a negedge, hold it until accepted, return at a negedge.
    task automatic applyStimulus(input logic [7:0] d, input logic s);
        int waitCycles = 0;
        DataIn    = d;
        Sof       = s;
        DataValid = 1'b1;
        while (DataReady !== 1'b1) begin
            @(negedge Clk);
            waitCycles++;
            if (waitCycles > 100) begin
                checkOutput("handshakeTimeout", 1'b0, 1'b1);
                DataValid = 1'b0;
                return;
            end
        end
        lastWait = waitCycles;
        @(posedge Clk);
        lastAcceptNeg = negCount + 1;
        modelAccept(d, s);
        @(negedge Clk);
        DataValid = 1'b0;
        Sof       = 1'b0;
    endtask

    task automatic sendConstFrame(input logic [7:0] d);
        for (int k = 0; k < 64; k++) applyStimulus(d, k == 0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Monitor: every pulse must match a queued expectation at the right cycle.
    always @(negedge Clk) begin
        negCount++;
        if (FrameDone === 1'b1 || FrameErr === 1'b1) begin
            checkOutput("doneErrExclusive", FrameDone & FrameErr, 1'b0);
        end
        if (FrameDone === 1'b1) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpectedDone", 1'b1, 1'b0);
            end else begin
                checkOutput("doneLatency", negCount, doneQ.pop_front());
                checkOutput("frameCells", Cells, frameQ.pop_front());
            end
        end
        if (FrameErr === 1'b1) begin
            if (errQ.size() == 0) begin
                checkOutput("unexpectedErr", 1'b1, 1'b0);
            end else begin
                checkOutput("errTiming", negCount, errQ.pop_front());
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        DataValid = 1'b1;
        DataIn    = 8'hC3;
        Sof       = 1'b1;

        // Reset held three cycles with a valid byte offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checkOutput("resetReady", DataReady, 1'b0);
            checkOutput("resetCells", Cells, '0);
            checkOutput("resetBusy", Busy, 1'b0);
            checkOutput("resetPulses", {FrameDone, FrameErr}, 2'b00);
        end
        Reset     = 1'b0;
        DataValid = 1'b0;
        Sof       = 1'b0;
        @(negedge Clk);
        checkOutput("readyAfterRelease", DataReady, 1'b1);

        // Full frame with byte k = k, then an immediate second frame.
        for (int k = 0; k < 64; k++) applyStimulus(8'(k), k == 0);
        checkOutput("cellsLowByte", Cells[7:0], 8'h00);
        checkOutput("cellsHighByte", Cells[511:504], 8'h3F);
        checkOutput("commitReadyLow", DataReady, 1'b0);
        checkOutput("commitBusyLow", Busy, 1'b0);
        applyStimulus(8'h81, 1'b1);
        checkOutput("commitStallOneCycle", lastWait, 1);
        checkOutput("busyInLoad", Busy, 1'b1);
        for (int k = 1; k < 64; k++) applyStimulus(8'(8'h80 + k), 1'b0);

        // Stray byte in IDLE, then an all-ones frame.
        idleCycles(2);
        applyStimulus(8'h12, 1'b0);
        sendConstFrame(8'hFF);
        checkOutput("allOnesCells", Cells, {512{1'b1}});

        // Mid-frame restart: 10 x 0xAA then a fresh 0x55 frame.
        for (int k = 0; k < 10; k++) applyStimulus(8'hAA, k == 0);
        sendConstFrame(8'h55);
        checkOutput("restartCells", Cells, {64{8'h55}});

        // Random data with random valid gaps.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 64; k++) begin
                if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 4));
                applyStimulus(8'($urandom_range(0, 255)), k == 0);
            end
        end

        // Five bytes, then a long stall.
        for (int k = 0; k < 5; k++) applyStimulus(8'(8'h30 + k), k == 0);
`ifdef CUBE_RX_TIMEOUT_EN
        errQ.push_back(lastAcceptNeg + TIMEOUT_CYCLES);
        modelBusy  = 1'b0;
        modelCount = 0;
        idleCycles(TIMEOUT_CYCLES + 4);
        checkOutput("timeoutBusy", Busy, 1'b0);
`else
        idleCycles(TIMEOUT_CYCLES + 4);
        checkOutput("stallBusy", Busy, 1'b1);
`endif
        checkOutput("stallCellsKept", Cells, modelCells);

        // Recover with a full frame of 0x0F.
        sendConstFrame(8'h0F);
        checkOutput("recoverCells", Cells, {64{8'h0F}});

        // Reset mid-frame clears Cells and produces no error.
        for (int k = 0; k < 10; k++) applyStimulus(8'h77, k == 0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midResetCells", Cells, '0);
        checkOutput("midResetBusy", Busy, 1'b0);
        checkOutput("midResetReady", DataReady, 1'b0);
        Reset = 1'b0;
        modelBusy   = 1'b0;
        modelCount  = 0;
        modelShadow = '0;
        modelCells  = '0;
        @(negedge Clk);
        checkOutput("midResetReadyBack", DataReady, 1'b1);
        sendConstFrame(8'hE7);

        idleCycles(5);
        checkOutput("framesPending", frameQ.size(), 0);
        checkOutput("errsPending", errQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/cube_frame_rx.md
# cube_frame_rx

Byte-stream frame receiver for the 8×8×8 LED cube. It accepts a 64-byte frame over a valid/ready byte interface, assembles it in a shadow buffer, and publishes it atomically as the 512-bit cell vector consumed by the cube output driver. It is the input end of the cell path, sitting between the host/serial link and the display side. The display never sees a partially loaded frame.

## Interface
- `TIMEOUT_CYCLES`, default 1024: idle cycles allowed between bytes inside a frame. Used only when the timeout feature is compiled in.
- `Clk`, input, 1: sole clock, rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `DataIn`, input, 8: frame byte.
- `DataValid`, input, 1: `DataIn` is valid this cycle.
- `Sof`, input, 1: start of frame; qualified by `DataValid`; marks byte 0.
- `DataReady`, output, 1: the receiver accepts a byte this cycle.
- `Cells`, output, 512: last complete frame; bit index = z·64 + y·8 + x.
- `FrameDone`, output, 1: one-cycle pulse when `Cells` is updated.
- `FrameErr`, output, 1: one-cycle pulse on a protocol error.
- `Busy`, output, 1: a frame is partially loaded.

## Operation
- A byte is accepted on a rising edge where `DataValid` and `DataReady` are both 1.
- Byte k (0..63) fills shadow bits [8k+7:8k]: z = k/8, y = k%8, bit x = `DataIn[x]`.
- A 6-bit byte counter and a registered FSM with states IDLE, LOAD and COMMIT control the load.
- **IDLE**
  - `DataReady` = 1.
  - An accepted byte with `Sof`=1 is written as byte 0, the counter is set to 1, and the FSM moves to LOAD.
  - An accepted byte with `Sof`=0 is discarded, `FrameErr` pulses, and the FSM stays in IDLE.
- **LOAD**
  - `DataReady` = 1 and `Busy` = 1.
  - An accepted byte with `Sof`=0 is written at the counter position and the counter increments.
  - An accepted byte with `Sof`=1 aborts the current frame: `FrameErr` pulses, the byte is written as byte 0, the counter is set to 1, and the FSM stays in LOAD.
  - When byte 63 is accepted:
    - `Cells` ← {byte63, shadow[503:0]};
    - `FrameDone` ← 1;
    - the FSM moves to COMMIT.
- **COMMIT**
  - `DataReady` = 0 for exactly one cycle, then the FSM returns to IDLE.
  - Any byte offered in this cycle is not accepted and stays pending at the source.
- `Cells` changes only on a frame commit or on reset.
- Counter wrap: the counter never wraps within a frame. Reaching 63 always ends the frame.
- A single-byte `Sof` frame never commits on its own.
- Stalls with `DataValid`=0 in LOAD are unlimited unless the timeout feature is compiled in.

## Timing
- Reset values (the cycle after `Reset` is sampled high):
  - FSM = IDLE, counter = 0, shadow = 0;
  - `Cells` = 0;
  - `FrameDone` = 0, `FrameErr` = 0, `Busy` = 0;
  - `DataReady` = 0 while `Reset` is high, then 1 from the first cycle after release.
- Reset asserted mid-frame discards the partial frame and clears `Cells`. No `FrameErr` is produced.
- `DataReady`, `Busy`, `FrameDone` and `FrameErr` are all registered outputs.
- Latency from the byte-63 handshake edge to the new `Cells` value and the `FrameDone` pulse is 1 cycle (both visible right after that edge).
- Minimum frame period is 65 cycles: 64 accepts plus 1 COMMIT cycle.
- `FrameErr` and `FrameDone` never pulse in the same cycle.

## Configuration
- Macro `CUBE_RX_TIMEOUT_EN`.
- **Defined:**
  - a watchdog counter runs in LOAD and resets on every accepted byte;
  - if it reaches `TIMEOUT_CYCLES` with no accept, the partial frame is dropped;
  - `FrameErr` pulses, the FSM moves to IDLE, and `Cells` is unchanged;
  - the watchdog is cleared in IDLE, in COMMIT and by `Reset`.
- **Undefined:**
  - no watchdog logic exists and LOAD waits indefinitely;
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Reset:** hold `Reset` for 3 cycles with `DataValid`=1.
  - Expect `Cells`=0, no pulses, and `DataReady`=0 during reset, then 1 one cycle after release.
- **Full frame:** send 64 back-to-back bytes with byte k = k and `Sof` on byte 0.
  - Expect `FrameDone` exactly 1 cycle after the last handshake, `Cells[7:0]`=0x00 and `Cells[511:504]`=0x3F.
  - Expect `DataReady`=0 for 1 cycle, then a second frame accepted immediately.
- **Stray byte:** send a byte with `Sof`=0 in IDLE, then a full frame of 0xFF.
  - Expect a `FrameErr` pulse and `Cells` all-ones after the frame (the stray byte is not included).
- **Mid-frame restart:** send 10 bytes of 0xAA, then a `Sof` frame of 64 × 0x55.
  - Expect `FrameErr` on the restart edge, and `Cells` = 0x55 repeated, committed after the 64th 0x55 byte.
- **Backpressure and stall:** insert random `DataValid` gaps and send a byte during COMMIT.
  - Expect no byte lost or duplicated and correct `Cells` contents.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** send 5 bytes, then idle for 16 cycles.
  - Expect a `FrameErr` pulse, `Busy`→0 and `Cells` unchanged.
  - The same stimulus with the macro undefined shows `Busy` still 1 and no `FrameErr`.
